// File: rtl/racetrack_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : racetrack_op_sequencer
//  Description : Phase-ordered control-line generator for a row of pNML
//                NAND/NOR SOT racetrack cells. Accepts one command at a time
//                (shift fwd/bwd, eval NOR/NAND, read) and drives the shared
//                pulse and level lines, capturing the row's read terminals.
//  Revision    : 1.0 - initial release
// ============================================================================
module racetrack_op_sequencer #(
   parameter int N_CELLS     = 32,
   parameter int CNT_W       = 6,
   parameter int SETUP_CYC   = 1,
   parameter int PULSE_CYC   = 2,
   parameter int RECOVER_CYC = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [2:0]         cmd_op_i,
   input  logic [CNT_W-1:0]   cmd_count_i,
   input  logic               cmd_bz_s_i,
   output logic               current_m_o,
   output logic               current_s_o,
   output logic               bz_m_o,
   output logic               bz_s_o,
   output logic               sel_nand_o,
   output logic               read_current_o,
   input  logic [N_CELLS-1:0] read_data_i,
   output logic               done_o,
   output logic               err_o,
   output logic [N_CELLS-1:0] rsp_data_o
);

   localparam logic [2:0] OP_SHIFT_FWD = 3'd0;
   localparam logic [2:0] OP_SHIFT_BWD = 3'd1;
   localparam logic [2:0] OP_EVAL_NOR  = 3'd2;
   localparam logic [2:0] OP_EVAL_NAND = 3'd3;
   localparam logic [2:0] OP_READ      = 3'd4;

   // Phase timer holds (phase length - 1) of the longest phase
   localparam int MAX_CYC_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_CYC   = (MAX_CYC_A > RECOVER_CYC) ? MAX_CYC_A : RECOVER_CYC;
   localparam int TMR_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TMR_W-1:0] SETUP_LD   = TMR_W'(SETUP_CYC - 1);
   localparam logic [TMR_W-1:0] PULSE_LD   = TMR_W'(PULSE_CYC - 1);
   localparam logic [TMR_W-1:0] RECOVER_LD = TMR_W'(RECOVER_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_ZERO   = '0;
   localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_PULSE   = 3'd2,
      S_RECOVER = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t             state_q;
   logic [2:0]         op_q;
   logic [TMR_W-1:0]   timer_q;
   logic [CNT_W-1:0]   loop_q;
   logic               cmd_ready_q;
   logic               current_m_q;
   logic               current_s_q;
   logic               bz_m_q;
   logic               bz_s_q;
   logic               sel_nand_q;
   logic               read_current_q;
   logic               done_q;
   logic               err_q;
   logic [N_CELLS-1:0] rsp_data_q;

   logic w_is_shift;
   logic w_is_eval;

   assign w_is_shift = (cmd_op_i == OP_SHIFT_FWD) || (cmd_op_i == OP_SHIFT_BWD);
   assign w_is_eval  = (cmd_op_i == OP_EVAL_NOR)  || (cmd_op_i == OP_EVAL_NAND);

   // Sequencer FSM; every output is a register set for the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         op_q           <= 3'd0;
         timer_q        <= TMR_ZERO;
         loop_q         <= CNT_ZERO;
         cmd_ready_q    <= 1'b1;
         current_m_q    <= 1'b0;
         current_s_q    <= 1'b0;
         bz_m_q         <= 1'b0;
         bz_s_q         <= 1'b0;
         sel_nand_q     <= 1'b0;
         read_current_q <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         rsp_data_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  op_q        <= cmd_op_i;
                  if (cmd_op_i > OP_READ) begin
                     // Illegal op: finish immediately, lines untouched
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (w_is_shift && (cmd_count_i == CNT_ZERO)) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= S_SETUP;
                     timer_q     <= SETUP_LD;
                     loop_q      <= w_is_shift ? cmd_count_i : CNT_ONE;
                     current_s_q <= (cmd_op_i == OP_SHIFT_BWD);
                     sel_nand_q  <= (cmd_op_i == OP_EVAL_NAND);
                     bz_s_q      <= w_is_eval & cmd_bz_s_i;
                  end
               end
            end
            S_SETUP: begin
               if (timer_q == TMR_ZERO) begin
                  state_q        <= S_PULSE;
                  timer_q        <= PULSE_LD;
                  current_m_q    <= (op_q == OP_SHIFT_FWD) || (op_q == OP_SHIFT_BWD);
                  bz_m_q         <= (op_q == OP_EVAL_NOR) || (op_q == OP_EVAL_NAND);
                  read_current_q <= (op_q == OP_READ);
               end else begin
                  timer_q <= timer_q - TMR_ONE;
               end
            end
            S_PULSE: begin
               if (timer_q == TMR_ZERO) begin
                  state_q        <= S_RECOVER;
                  timer_q        <= RECOVER_LD;
                  current_m_q    <= 1'b0;
                  bz_m_q         <= 1'b0;
                  read_current_q <= 1'b0;
               end else begin
                  timer_q <= timer_q - TMR_ONE;
               end
            end
            S_RECOVER: begin
               if (timer_q == TMR_ZERO) begin
                  // Counter stops at 1 -> last iteration; never decrements past zero
                  loop_q <= loop_q - CNT_ONE;
                  if (loop_q == CNT_ONE) begin
                     state_q     <= S_DONE;
                     done_q      <= 1'b1;
                     current_s_q <= 1'b0;
                     sel_nand_q  <= 1'b0;
                     bz_s_q      <= 1'b0;
                     if (op_q == OP_READ) begin
                        rsp_data_q <= read_data_i;
                     end
                  end else begin
                     state_q <= S_SETUP;
                     timer_q <= SETUP_LD;
                  end
               end else begin
                  timer_q <= timer_q - TMR_ONE;
               end
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               done_q      <= 1'b0;
               err_q       <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= S_IDLE;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready_o    = cmd_ready_q;
   assign current_m_o    = current_m_q;
   assign current_s_o    = current_s_q;
   assign bz_m_o         = bz_m_q;
   assign bz_s_o         = bz_s_q;
   assign sel_nand_o     = sel_nand_q;
   assign read_current_o = read_current_q;
   assign done_o         = done_q;
   assign err_o          = err_q;
   assign rsp_data_o     = rsp_data_q;

endmodule
`default_nettype wire
